button_event_gen: RTL

- Downstream consumer of the NES gamepad receiver's eight active-high button levels (1 = pressed).
- Debounces each button and detects press/release edges.
- Generates auto-repeat events for the four direction buttons.
- Queues events, one per cycle, into a 4-entry FIFO with a valid/ready interface for game logic.
- Also exports debounced levels and one-cycle edge pulses.

---
 rtl/button_event_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced button levels, edge pulses, auto-repeat and a 4-deep event queue
//
// Purpose: takes the eight raw active-high button levels from the gamepad
// receiver and turns them into debounced levels, one-cycle press/release
// pulses, and a stream of {kind, button} events for game logic.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-low reset
//   btn_in[7:0]    raw pressed levels (A, B, select, start, up, down, left, right)
//   repeat_en      enables auto-repeat on the direction buttons (bits 4-7)
//   btn_state[7:0] debounced levels
//   press_pulse    one-cycle pulse per bit when btn_state rises
//   release_pulse  one-cycle pulse per bit when btn_state falls
//   event_valid    queue head valid
//   event_data     {kind[1:0], button[2:0]}; kind 00 press, 01 release, 10 repeat
//   event_ready    consumer accepts the head when event_valid is also high
//   overflow       sticky flag: an event was dropped
//   overflow_clr   clears overflow (a simultaneous drop wins)
module button_event_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_in,
  input  logic       repeat_en,
  output logic [7:0] btn_state,
  output logic [7:0] press_pulse,
  output logic [7:0] release_pulse,
  output logic       event_valid,
  output logic [4:0] event_data,
  input  logic       event_ready,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes the next fire land exactly PERIOD cycles later.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [DW-1:0] cnt [8];
  logic [RW-1:0] rpt [4];
  logic [7:0]    diff, flip, rise, fall, rep_evt;
  logic [7:0]    press_pend, release_pend, repeat_pend;
  logic [7:0]    press_clr, release_clr, repeat_clr;
  logic [4:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          pop, can_push, push, drop;
  logic [4:0]    push_data;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  assign diff        = btn_in ^ btn_state;
  assign rise        = flip & ~btn_state;
  assign fall        = flip & btn_state;
  assign event_valid = (count != 3'd0);
  assign event_data  = event_valid ? mem[rd_ptr] : 5'd0;
  assign pop         = event_valid && event_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign can_push    = (count != 3'd4) || pop;

  always_comb begin
    flip    = '0;
    rep_evt = '0;
    for (int i = 0; i < 8; i++) begin
      flip[i] = diff[i] && (cnt[i] == DB_LAST);
    end
    // A button changing state this cycle restarts its repeat timer instead of firing.
    for (int j = 0; j < 4; j++) begin
      rep_evt[j+4] = !flip[j+4] && btn_state[j+4] && repeat_en && (rpt[j] == RPT_LAST);
    end
  end

  // Fixed priority: presses, then releases, then repeats; lowest button first.
  always_comb begin
    press_clr   = '0;
    release_clr = '0;
    repeat_clr  = '0;
    push        = 1'b0;
    push_data   = 5'd0;
    if (can_push) begin
      if (|press_pend) begin
        push                          = 1'b1;
        push_data                     = {2'b00, lowest(press_pend)};
        press_clr[lowest(press_pend)] = 1'b1;
      end else if (|release_pend) begin
        push                              = 1'b1;
        push_data                         = {2'b01, lowest(release_pend)};
        release_clr[lowest(release_pend)] = 1'b1;
      end else if (|repeat_pend) begin
        push                            = 1'b1;
        push_data                       = {2'b10, lowest(repeat_pend)};
        repeat_clr[lowest(repeat_pend)] = 1'b1;
      end
    end
  end

  // Only a pending bit that stays occupied loses the incoming event.
  assign drop = |((press_pend & ~press_clr & rise) |
                  (release_pend & ~release_clr & fall) |
                  (repeat_pend & ~repeat_clr & rep_evt));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      for (int j = 0; j < 4; j++) rpt[j] <= '0;
      for (int k = 0; k < 4; k++) mem[k] <= '0;
      btn_state     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      press_pend    <= '0;
      release_pend  <= '0;
      repeat_pend   <= '0;
      overflow      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!diff[i] || flip[i]) cnt[i] <= '0;
        else                     cnt[i] <= cnt[i] + 1'b1;
      end
      for (int j = 0; j < 4; j++) begin
        if (flip[j+4] || !(btn_state[j+4] && repeat_en)) rpt[j] <= '0;
        else if (rpt[j] == RPT_LAST)                     rpt[j] <= RPT_RELOAD;
        else                                             rpt[j] <= rpt[j] + 1'b1;
      end
      btn_state     <= btn_state ^ flip;
      press_pulse   <= rise;
      release_pulse <= fall;
      // Set after clear: a bit drained and re-armed in one cycle stays set.
      press_pend    <= (press_pend & ~press_clr) | rise;
      release_pend  <= (release_pend & ~release_clr) | fall;
      repeat_pend   <= (repeat_pend & ~repeat_clr) | rep_evt;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule
